// File: rtl/vec_shift_pkg.sv
// Shared types and saturation-limit helpers for the vector shift/scale unit.
// Optional round-half-up right shifts are enabled with VEC_SHIFT_ROUND_EN.
package vec_shift_pkg;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_t;

    localparam int DEF_IWIDTH  = 10;
    localparam int DEF_NINPUTS = 8;

    function automatic longint sat_umax(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint sat_umin(input int w);
        return longint'(w) * 0;
    endfunction

    function automatic longint sat_smax(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_smin(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/vec_shift_lane.sv
// Combinational single-element shift, optional rounding, and saturation.
// VEC_SHIFT_ROUND_EN selects round-half-up for in-range right shifts.
module vec_shift_lane
    import vec_shift_pkg::*;
#(
    parameter int IWIDTH = 10,
    parameter int SHW    = $clog2(IWIDTH) + 1
) (
    input  logic [IWIDTH-1:0] x_i,
    input  logic [SHW-1:0]    shamt_i,
    input  logic              dir_i,
    input  logic              signed_i,
    output logic [IWIDTH-1:0] result_o,
    output logic              sat_o
);

    localparam int WW = 2 * IWIDTH;
    localparam logic [IWIDTH-1:0] UMAX = IWIDTH'(sat_umax(IWIDTH));
    localparam logic [IWIDTH-1:0] SMAX = IWIDTH'(sat_smax(IWIDTH));
    localparam logic [IWIDTH-1:0] SMIN = IWIDTH'(sat_smin(IWIDTH));
    localparam logic [SHW-1:0]    SH_W = SHW'(IWIDTH);

    shift_dir_t        dir;
    logic              sign;
    logic              big;
    logic              ovf;
    logic [IWIDTH-1:0] rsh;
    logic [WW-1:0]     lwide;
`ifdef VEC_SHIFT_ROUND_EN
    logic [IWIDTH:0]   rnd;
`endif

    assign dir  = shift_dir_t'(dir_i);
    assign sign = signed_i & x_i[IWIDTH-1];
    assign big  = (shamt_i >= SH_W);

    always_comb begin
        rsh   = '0;
        lwide = '0;
        ovf   = 1'b0;
        if (big) begin
            rsh = {IWIDTH{sign}};
        end else begin
            rsh = IWIDTH'($signed({sign, x_i}) >>> shamt_i);
        end
`ifdef VEC_SHIFT_ROUND_EN
        rnd = '0;
        if (!big && shamt_i != '0) begin
            rnd = {sign, x_i} + ((IWIDTH+1)'(1) << (shamt_i - SHW'(1)));
            if (signed_i) begin
                rsh = IWIDTH'($signed(rnd) >>> shamt_i);
            end else begin
                rsh = IWIDTH'(rnd >> shamt_i);
            end
        end
`endif
        // Left shift at double width, then detect bits lost above the lane.
        lwide = {{IWIDTH{sign}}, x_i} << shamt_i;
        if (big) begin
            ovf = |x_i;
        end else if (signed_i) begin
            ovf = !(&lwide[WW-1:IWIDTH-1] || ~|lwide[WW-1:IWIDTH-1]);
        end else begin
            ovf = |lwide[WW-1:IWIDTH];
        end
    end

    always_comb begin
        result_o = rsh;
        sat_o    = 1'b0;
        if (dir == SHIFT_LEFT) begin
            sat_o = ovf;
            if (ovf) begin
                result_o = signed_i ? (sign ? SMIN : SMAX) : UMAX;
            end else if (big) begin
                result_o = '0;
            end else begin
                result_o = lwide[IWIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/vec_shift_scale.sv
// Two-stage valid/ready pipeline applying a per-element shift/scale.
// Build option VEC_SHIFT_ROUND_EN (in vec_shift_lane) rounds right shifts.
module vec_shift_scale
    import vec_shift_pkg::*;
#(
    parameter int IWIDTH  = DEF_IWIDTH,
    parameter int NINPUTS = DEF_NINPUTS,
    parameter int SHW     = $clog2(IWIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NINPUTS*IWIDTH-1:0] data,
    input  logic [SHW-1:0]            shamt,
    input  logic                      dir,
    input  logic                      is_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NINPUTS*IWIDTH-1:0] out,
    output logic [NINPUTS-1:0]        out_sat
);

    localparam int VW = NINPUTS * IWIDTH;

    logic              s1_valid_q, s1_valid_d;
    logic [VW-1:0]     data_q, data_d;
    logic [SHW-1:0]    shamt_q, shamt_d;
    logic              dir_q, dir_d;
    logic              sgn_q, sgn_d;
    logic              s2_valid_q, s2_valid_d;
    logic [VW-1:0]     out_q, out_d;
    logic [NINPUTS-1:0] sat_q, sat_d;

    logic [VW-1:0]      res_w;
    logic [NINPUTS-1:0] sat_w;
    logic               s1_adv;
    logic               s2_adv;

    for (genvar g = 0; g < NINPUTS; g++) begin : g_lane
        vec_shift_lane #(
            .IWIDTH (IWIDTH),
            .SHW    (SHW)
        ) u_lane (
            .x_i      (data_q[g*IWIDTH +: IWIDTH]),
            .shamt_i  (shamt_q),
            .dir_i    (dir_q),
            .signed_i (sgn_q),
            .result_o (res_w[g*IWIDTH +: IWIDTH]),
            .sat_o    (sat_w[g])
        );
    end

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        dir_d      = dir_q;
        sgn_d      = sgn_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        sat_d      = sat_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                data_d  = data;
                shamt_d = shamt;
                dir_d   = dir;
                sgn_d   = is_signed;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = res_w;
                sat_d = sat_w;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            data_q     <= '0;
            shamt_q    <= '0;
            dir_q      <= 1'b0;
            sgn_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            sat_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            dir_q      <= dir_d;
            sgn_q      <= sgn_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            sat_q      <= sat_d;
        end
    end

    assign in_ready  = !rst && s1_adv;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_vec_shift_scale.sv
// Scoreboard testbench for vec_shift_scale (IWIDTH=10, NINPUTS=8).
// Expectations follow VEC_SHIFT_ROUND_EN when it is defined for the build.
module tb_vec_shift_scale;

    localparam int W  = 10;
    localparam int N  = 8;
    localparam int VW = W * N;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [N-1:0] s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    vec_t         data = '0;
    logic [4:0]   shamt = '0;
    logic         dir = 1'b0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    vec_t         out;
    logic [N-1:0] out_sat;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_shift_scale #(.IWIDTH(W), .NINPUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .shamt     (shamt),
        .dir       (dir),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out got=%h sat=%b", out, out_sat);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out !== e.v || out_sat !== e.s) begin
                    n_bad++;
                    $display("FAIL scoreboard got=%h sat=%b exp=%h sat=%b",
                             out, out_sat, e.v, e.s);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint r;
        r = a / b;
        if ((a % b) != 0 && a < 0) r = r - 1;
        return r;
    endfunction

    function automatic void model_elem(input logic [W-1:0] x, input int sh,
                                       input bit left, input bit sg,
                                       output logic [W-1:0] r, output bit st);
        longint v, res, d, lo, hi;
        v   = sg ? longint'($signed(x)) : longint'(x);
        d   = longint'(1) << sh;
        lo  = sg ? -512 : 0;
        hi  = sg ? 511 : 1023;
        st  = 1'b0;
        if (left) begin
            res = v * d;
            if (res > hi) begin
                res = hi;
                st  = 1'b1;
            end else if (res < lo) begin
                res = lo;
                st  = 1'b1;
            end
        end else begin
            res = fdiv(v, d);
`ifdef VEC_SHIFT_ROUND_EN
            if (sh >= 1 && sh <= W - 1) res = fdiv(v + d / 2, d);
`endif
        end
        r = res[W-1:0];
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c);
        vec_t v;
        v = '0;
        v[9:0]   = 10'(a);
        v[19:10] = 10'(b);
        v[29:20] = 10'(c);
        return v;
    endfunction

    task automatic send(input vec_t v, input logic [4:0] sh, input bit d,
                        input bit sg, input vec_t ev, input logic [N-1:0] es,
                        output int waits);
        exp_t e;
        data      = v;
        shamt     = sh;
        dir       = d;
        is_signed = sg;
        in_valid  = 1'b1;
        waits     = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
        end else begin
            e.v = ev;
            e.s = es;
            q.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_m(input vec_t v, input logic [4:0] sh, input bit d,
                          input bit sg, output int waits);
        vec_t         ev;
        logic [N-1:0] es;
        logic [W-1:0] r;
        bit           st;
        for (int i = 0; i < N; i++) begin
            model_elem(v[i*W +: W], int'(sh), d, sg, r, st);
            ev[i*W +: W] = r;
            es[i]        = st;
        end
        send(v, sh, d, sg, ev, es, waits);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            step();
            k++;
        end
        repeat (3) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ctl out_valid=%b in_ready=%b exp=0/0",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (out !== '0 || out_sat !== '0) begin
            n_bad++;
            $display("FAIL rst_data out=%h sat=%b exp=0", out, out_sat);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_release in_ready=%b exp=1", in_ready);
        end
        step();
    endtask

    task automatic test_unsigned_right();
        int   w;
        vec_t ev;
`ifdef VEC_SHIFT_ROUND_EN
        ev = mk(512, 4, 0);
`else
        ev = mk(511, 3, 0);
`endif
        out_ready = 1'b1;
        send(mk(1023, 7, 0), 5'd1, 1'b0, 1'b0, ev, '0, w);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early out_valid=%b exp=0", out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_sat !== '0) begin
            n_bad++;
            $display("FAIL latency out_valid=%b sat=%b exp=1/0",
                     out_valid, out_sat);
        end
        wait_drain();
    endtask

    task automatic test_signed_right();
        int   w;
        vec_t ev;
`ifdef VEC_SHIFT_ROUND_EN
        ev = mk(-3, 256, -256);
`else
        ev = mk(-4, 255, -256);
`endif
        send(mk(-7, 511, -512), 5'd1, 1'b0, 1'b1, ev, '0, w);
        send(mk(-7, 511, -512), 5'd12, 1'b0, 1'b1, mk(-1, 0, -1), '0, w);
        send(mk(-7, 511, -512), 5'd0, 1'b0, 1'b1, mk(-7, 511, -512), '0, w);
        wait_drain();
    endtask

    task automatic test_left_sat();
        int w;
        send(mk(200, -200, 100), 5'd2, 1'b1, 1'b1,
             mk(511, -512, 400), 8'b0000_0011, w);
        send(mk(300, 255, 0), 5'd2, 1'b1, 1'b0,
             mk(1023, 1020, 0), 8'b0000_0001, w);
        send(mk(5, 0, -1), 5'd10, 1'b1, 1'b1,
             mk(511, 0, -512), 8'b0000_0101, w);
        send(mk(5, 0, 1), 5'd31, 1'b1, 1'b0,
             mk(1023, 0, 1023), 8'b0000_0101, w);
        send(mk(-9, 9, 0), 5'd0, 1'b1, 1'b1, mk(-9, 9, 0), '0, w);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        stalls    = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_m(vec_t'({$urandom, $urandom, $urandom}), 5'(i + 1),
                   1'b0, i[0], w);
            stalls += w;
        end
        n_cmp++;
        if (stalls != 0) begin
            n_bad++;
            $display("FAIL back_to_back stalls=%0d exp=0", stalls);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        bit           saw_block;
        vec_t         held;
        logic [N-1:0] held_s;
        bit           have;
        saw_block = 1'b0;
        have      = 1'b0;
        out_ready = 1'b1;
        fork
            begin
                int w;
                for (int i = 0; i < 6; i++) begin
                    send_m(vec_t'({$urandom, $urandom, $urandom}),
                           5'(i % 4), 1'b1, i[1], w);
                end
            end
            begin
                step();
                step();
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (in_ready === 1'b0) saw_block = 1'b1;
                    if (out_valid) begin
                        if (have) begin
                            n_cmp++;
                            if (out !== held || out_sat !== held_s) begin
                                n_bad++;
                                $display("FAIL stall_hold got=%h exp=%h",
                                         out, held);
                            end
                        end
                        held   = out;
                        held_s = out_sat;
                        have   = 1'b1;
                    end
                    step();
                end
                out_ready = 1'b1;
            end
        join
        n_cmp++;
        if (!saw_block) begin
            n_bad++;
            $display("FAIL in_ready_block got=1 exp=0");
        end
        wait_drain();
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                int w;
                for (int i = 0; i < 24; i++) begin
                    send_m(vec_t'({$urandom, $urandom, $urandom}),
                           5'($urandom_range(0, 13)), 1'($urandom),
                           1'($urandom), w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 3) != 0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        int w;
        out_ready = 1'b0;
        send_m(mk(1, 2, 3), 5'd1, 1'b1, 1'b0, w);
        send_m(mk(4, 5, 6), 5'd1, 1'b1, 1'b0, w);
        rst = 1'b1;
        #1;
        q.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== '0) begin
            n_bad++;
            $display("FAIL midrst out_valid=%b in_ready=%b out=%h exp=0/0/0",
                     out_valid, in_ready, out);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_release in_ready=%b exp=1", in_ready);
        end
        out_ready = 1'b1;
        step();
        send_m(mk(100, -100, 7), 5'd3, 1'b1, 1'b1, w);
        send_m(mk(64, 65, 66), 5'd2, 1'b0, 1'b0, w);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_unsigned_right();
        test_signed_right();
        test_left_sat();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
